// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS Avalon-MM load/store unit: access sizes, FSM states
// and the byte-lane mask helper.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE:  size_bytes = 4'd1;
      SZ_HALF:  size_bytes = 4'd2;
      SZ_WORD:  size_bytes = 4'd4;
      SZ_DWORD: size_bytes = 4'd8;
      default:  size_bytes = 4'd1;
    endcase
  endfunction

  // Unshifted byteenable pattern; the caller truncates to its lane count.
  function automatic logic [7:0] be_base(input size_e sz);
    case (sz)
      SZ_BYTE:  be_base = 8'h01;
      SZ_HALF:  be_base = 8'h03;
      SZ_WORD:  be_base = 8'h0F;
      SZ_DWORD: be_base = 8'hFF;
      default:  be_base = 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_lane_extract.sv
// Load-data lane extraction: shifts the addressed lane down to bit 0, keeps
// the access width and fills the upper bits with zeros or the sign bit.
module mips_bus_lane_extract
  import mips_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_readdata,
  input  logic [LW-1:0]     i_lane,
  input  size_e             i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_shift;
  logic              w_msb;
  logic              w_fill;
  int                w_nbits;

  always_comb begin
    w_shift = i_readdata >> {i_lane, 3'b000};
    w_nbits = DATA_W;
    w_msb   = 1'b0;
    o_rdata = '0;
    case (i_size)
      SZ_BYTE:  begin w_nbits = 8;      w_msb = w_shift[7];        end
      SZ_HALF:  begin w_nbits = 16;     w_msb = w_shift[15];       end
      SZ_WORD:  begin w_nbits = 32;     w_msb = w_shift[31];       end
      SZ_DWORD: begin w_nbits = DATA_W; w_msb = w_shift[DATA_W-1]; end
      default:  begin w_nbits = DATA_W; w_msb = 1'b0;              end
    endcase
    w_fill = i_signed & w_msb;
    for (int i = 0; i < DATA_W; i++) begin
      o_rdata[i] = (i < w_nbits) ? w_shift[i] : w_fill;
    end
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the multicycle MIPS core to an Avalon-MM master:
// lane alignment, byteenables, load extension, misalignment and stall timeout.
module mips_bus_lsu
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_W-1:0]     o_resp_rdata,
  output logic                  o_resp_error,
  output logic [ADDR_W-1:0]     o_address,
  output logic                  o_read,
  output logic                  o_write,
  input  logic                  i_waitrequest,
  output logic [DATA_W-1:0]     o_writedata,
  output logic [DATA_W/8-1:0]   o_byteenable,
  input  logic [DATA_W-1:0]     i_readdata
);

  localparam int NB    = DATA_W / 8;
  localparam int LW    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_address;
  logic [NB-1:0]     r_byteenable;
  logic [DATA_W-1:0] r_writedata;
  logic              r_read;
  logic              r_write;
  logic              r_resp_valid;
  logic              r_resp_error;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [LW-1:0]     r_lane;
  size_e             r_size;
  logic              r_signed;

  logic [LW-1:0]     w_lane;
  size_e             w_size;
  logic [7:0]        w_be_wide;
  logic [NB-1:0]     w_be;
  logic              w_misaligned;
  logic              w_timeout;
  logic [DATA_W-1:0] w_ext_rdata;

  assign w_lane       = i_req_addr[LW-1:0];
  assign w_size       = size_e'(i_req_size);
  assign w_be_wide    = be_base(w_size);
  assign w_be         = w_be_wide[NB-1:0] << w_lane;
  // A dword on a 32-bit bus can never be serviced in one beat.
  assign w_misaligned = ((w_lane & LW'(size_bytes(w_size) - 4'd1)) != '0) ||
                        ((w_size == SZ_DWORD) && (DATA_W == 32));
  assign w_timeout    = (TIMEOUT > 0) && i_waitrequest &&
                        (r_cnt == CNT_W'(TIMEOUT - 1));

  mips_bus_lane_extract #(
    .DATA_W (DATA_W),
    .LW     (LW)
  ) u_extract (
    .i_readdata (i_readdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_signed   (r_signed),
    .o_rdata    (w_ext_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_next = w_misaligned ? RESP : ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        if (!i_waitrequest || w_timeout) begin
          w_next = RESP;
        end else begin
          w_next = ACCESS;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_cnt        <= '0;
      r_lane       <= '0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= (w_next == RESP);
      case (r_state)
        IDLE: begin
          r_resp_error <= 1'b0;
          if (i_req_valid && w_misaligned) begin
            r_resp_error <= 1'b1;
            r_resp_rdata <= '0;
          end else if (i_req_valid) begin
            r_address    <= {i_req_addr[ADDR_W-1:LW], {LW{1'b0}}};
            r_byteenable <= w_be;
            r_writedata  <= i_req_wdata << {w_lane, 3'b000};
            r_read       <= ~i_req_write;
            r_write      <= i_req_write;
            r_lane       <= w_lane;
            r_size       <= w_size;
            r_signed     <= i_req_signed;
            r_cnt        <= '0;
          end
        end
        ACCESS: begin
          if (!i_waitrequest) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_rdata <= r_read ? w_ext_rdata : '0;
            r_resp_error <= 1'b0;
            r_cnt        <= '0;
          end else if (w_timeout) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b1;
            r_cnt        <= '0;
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_resp_error <= 1'b0;
        end
        default: begin
          r_resp_error <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_error = r_resp_error & r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_address    = r_address;
  assign o_read       = r_read;
  assign o_write      = r_write;
  assign o_writedata  = r_writedata;
  assign o_byteenable = r_byteenable;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed, table-driven bench for mips_bus_lsu: a 32-bit instance with a
// stall timeout of 8 and a 64-bit instance with the timeout disabled.
module tb_mips_bus_lsu;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        v32, v64;
  logic        wr;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        waitreq;
  logic [63:0] rdata;

  logic        rdy32, rv32, err32, rd32, wt32;
  logic [31:0] rr32, ad32, wd32;
  logic [3:0]  be32;
  logic        rdy64, rv64, err64, rd64, wt64;
  logic [63:0] rr64, wd64;
  logic [31:0] ad64;
  logic [7:0]  be64;

  int checks   = 0;
  int failures = 0;
  bit sel_wide = 1'b0;

  always #5 clk = ~clk;

  mips_bus_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u32 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(v32), .o_req_ready(rdy32),
    .i_req_write(wr), .i_req_size(size), .i_req_signed(sgn), .i_req_addr(addr),
    .i_req_wdata(wdata[31:0]), .o_resp_valid(rv32), .o_resp_rdata(rr32),
    .o_resp_error(err32), .o_address(ad32), .o_read(rd32), .o_write(wt32),
    .i_waitrequest(waitreq), .o_writedata(wd32), .o_byteenable(be32),
    .i_readdata(rdata[31:0]));

  mips_bus_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) u64 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(v64), .o_req_ready(rdy64),
    .i_req_write(wr), .i_req_size(size), .i_req_signed(sgn), .i_req_addr(addr),
    .i_req_wdata(wdata), .o_resp_valid(rv64), .o_resp_rdata(rr64),
    .o_resp_error(err64), .o_address(ad64), .o_read(rd64), .o_write(wt64),
    .i_waitrequest(waitreq), .o_writedata(wd64), .o_byteenable(be64),
    .i_readdata(rdata));

  logic        m_rdy, m_rv, m_err, m_rd, m_wt;
  logic [63:0] m_rr, m_wd;
  logic [31:0] m_ad;
  logic [7:0]  m_be;
  assign m_rdy = sel_wide ? rdy64 : rdy32;
  assign m_rv  = sel_wide ? rv64  : rv32;
  assign m_err = sel_wide ? err64 : err32;
  assign m_rd  = sel_wide ? rd64  : rd32;
  assign m_wt  = sel_wide ? wt64  : wt32;
  assign m_rr  = sel_wide ? rr64  : {32'd0, rr32};
  assign m_wd  = sel_wide ? wd64  : {32'd0, wd32};
  assign m_ad  = sel_wide ? ad64  : ad32;
  assign m_be  = sel_wide ? be64  : {4'd0, be32};

  typedef struct {
    bit          wide;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    logic        err;
    logic [31:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic w_r, logic [1:0] sz, logic s, logic [31:0] a,
                              logic [63:0] wd, logic [63:0] rd, int ws, logic e,
                              logic [31:0] ea, logic [7:0] eb, logic [63:0] ewd,
                              logic [63:0] erd);
    vec_t v;
    v.wide = w; v.wr = w_r; v.size = sz; v.sgn = s; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.waits = ws; v.err = e; v.e_addr = ea; v.e_be = eb;
    v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    sel_wide = v.wide;
    @(negedge clk);
    chk({t, "_ready"}, {63'd0, m_rdy}, 64'd1);
    wr = v.wr; size = v.size; sgn = v.sgn; addr = v.addr; wdata = v.wdata;
    rdata = v.rdata; waitreq = 1'b0;
    if (v.wide) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    if (v.err) begin
      chk({t, "_mis_rv"}, {63'd0, m_rv}, 64'd1);
      chk({t, "_mis_err"}, {63'd0, m_err}, 64'd1);
      chk({t, "_mis_strobes"}, {62'd0, m_rd, m_wt}, 64'd0);
      @(negedge clk);
      chk({t, "_mis_rv_pulse"}, {62'd0, m_rv, m_rd}, 64'd0);
    end else begin
      for (int k = 0; k <= v.waits; k++) begin
        chk({t, "_strobes"}, {62'd0, m_rd, m_wt}, {62'd0, ~v.wr, v.wr});
        chk({t, "_address"}, {32'd0, m_ad}, {32'd0, v.e_addr});
        chk({t, "_be"}, {56'd0, m_be}, {56'd0, v.e_be});
        chk({t, "_wdata"}, m_wd, v.e_wdata);
        chk({t, "_rv_early"}, {63'd0, m_rv}, 64'd0);
        waitreq = (k < v.waits);
        @(negedge clk);
      end
      waitreq = 1'b0;
      chk({t, "_strobes_off"}, {62'd0, m_rd, m_wt}, 64'd0);
      chk({t, "_rv"}, {63'd0, m_rv}, 64'd1);
      chk({t, "_err"}, {63'd0, m_err}, 64'd0);
      chk({t, "_rdata"}, m_rr, v.e_rdata);
      @(negedge clk);
      chk({t, "_rv_pulse"}, {63'd0, m_rv}, 64'd0);
      chk({t, "_rdata_hold"}, m_rr, v.e_rdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; v32 = 1'b0; v64 = 1'b0; wr = 1'b0; size = 2'd0; sgn = 1'b0;
    addr = 32'd0; wdata = 64'd0; waitreq = 1'b0; rdata = 64'd0;

    //    wide wr size sgn addr          wdata                  rdata                  ws err e_addr        e_be   e_wdata                e_rdata
    tbl.push_back(mk(0, 1, 2'd2, 0, 32'h10000004, 64'hDEADBEEF, 64'd0, 0, 0, 32'h10000004, 8'h0F, 64'hDEADBEEF, 64'd0));
    tbl.push_back(mk(0, 0, 2'd0, 1, 32'h10000003, 64'd0, 64'h80FF1234, 0, 0, 32'h10000000, 8'h08, 64'd0, 64'hFFFFFF80));
    tbl.push_back(mk(0, 0, 2'd0, 0, 32'h10000003, 64'd0, 64'h80FF1234, 0, 0, 32'h10000000, 8'h08, 64'd0, 64'h00000080));
    tbl.push_back(mk(0, 1, 2'd1, 0, 32'h10000002, 64'h0000ABCD, 64'd0, 3, 0, 32'h10000000, 8'h0C, 64'hABCD0000, 64'd0));
    tbl.push_back(mk(0, 0, 2'd1, 0, 32'h10000001, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0));
    tbl.push_back(mk(0, 0, 2'd1, 1, 32'h10000002, 64'd0, 64'h80017FFF, 0, 0, 32'h10000000, 8'h0C, 64'd0, 64'hFFFF8001));
    tbl.push_back(mk(0, 0, 2'd1, 0, 32'h10000000, 64'd0, 64'h1234F00D, 0, 0, 32'h10000000, 8'h03, 64'd0, 64'h0000F00D));
    tbl.push_back(mk(0, 1, 2'd0, 0, 32'h20000001, 64'hFFFFFF5A, 64'd0, 1, 0, 32'h20000000, 8'h02, 64'hFFFF5A00, 64'd0));
    tbl.push_back(mk(0, 0, 2'd3, 0, 32'h10000000, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0));
    tbl.push_back(mk(0, 0, 2'd2, 1, 32'h10000008, 64'd0, 64'h89ABCDEF, 2, 0, 32'h10000008, 8'h0F, 64'd0, 64'h89ABCDEF));
    tbl.push_back(mk(0, 0, 2'd2, 0, 32'h10000002, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0));
    tbl.push_back(mk(0, 0, 2'd0, 1, 32'h10000002, 64'd0, 64'h007F0000, 0, 0, 32'h10000000, 8'h04, 64'd0, 64'h0000007F));
    tbl.push_back(mk(1, 0, 2'd1, 1, 32'h10000006, 64'd0, 64'h8001000000000000, 0, 0, 32'h10000000, 8'hC0, 64'd0, 64'hFFFFFFFFFFFF8001));
    tbl.push_back(mk(1, 0, 2'd3, 0, 32'h10000008, 64'd0, 64'h0123456789ABCDEF, 10, 0, 32'h10000008, 8'hFF, 64'd0, 64'h0123456789ABCDEF));
    tbl.push_back(mk(1, 1, 2'd2, 0, 32'h10000014, 64'h00000000CAFEF00D, 64'd0, 0, 0, 32'h10000010, 8'hF0, 64'hCAFEF00D00000000, 64'd0));
    tbl.push_back(mk(1, 0, 2'd3, 0, 32'h10000004, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0));
    tbl.push_back(mk(1, 0, 2'd0, 0, 32'h10000005, 64'd0, 64'h00009A0000000000, 0, 0, 32'h10000000, 8'h20, 64'd0, 64'h000000000000009A));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    sel_wide = 1'b0;
    chk("rst32_outs", {56'd0, rd32, wt32, rv32, err32, be32}, 64'd0);
    chk("rst32_addr_wd", {ad32, wd32}, 64'd0);
    chk("rst32_ready", {63'd0, rdy32}, 64'd1);
    chk("rst64_outs", {52'd0, rd64, wt64, rv64, err64, be64}, 64'd0);
    chk("rst64_rdata", rr64 | wd64 | {32'd0, ad64}, 64'd0);

    foreach (tbl[i]) run(tbl[i], i);

    // Reset in the middle of a stalled access: abort with no response.
    sel_wide = 1'b0;
    @(negedge clk);
    wr = 1'b0; size = 2'd2; addr = 32'h40000000; waitreq = 1'b1; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    chk("rststall_read_on", {63'd0, rd32}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    waitreq = 1'b0;
    chk("rststall_read", {63'd0, rd32}, 64'd0);
    chk("rststall_ready", {63'd0, rdy32}, 64'd1);
    chk("rststall_rv", {63'd0, rv32}, 64'd0);
    chk("rststall_addr", {32'd0, ad32}, 64'd0);
    chk("rststall_rdata", {32'd0, rr32}, 64'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rv32 || rd32) cnt++;
    end
    chk("rststall_no_resp", cnt, 64'd0);

    // Stall timeout on the 32-bit instance after a load with non-zero data.
    run(tbl[1], 100);
    @(negedge clk);
    wr = 1'b0; size = 2'd2; addr = 32'h30000000; waitreq = 1'b1; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!rd32) break;
      cnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", cnt, 64'd8);
    chk("timeout_rv", {63'd0, rv32}, 64'd1);
    chk("timeout_err", {63'd0, err32}, 64'd1);
    chk("timeout_rdata", {32'd0, rr32}, 64'd0);
    waitreq = 1'b0;
    @(negedge clk);
    chk("timeout_idle", {61'd0, rdy32, rv32, rd32}, 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
